keypad_row_driver: RTL
======================

Name: keypad_row_driver

Overview:
- Drive side of the keypad interface: walks a one-hot row strobe across the keypad matrix and samples the column return lines.
- Debounces a detected contact, encodes it to a key code and emits a one-cycle key_valid pulse.
- Feeds game/control logic downstream, replacing raw column polling.

Parameters:
- ROWS, 4, number of row drive lines.
- COLS, 3, number of column sense lines.
- SCAN_DIV, 1000, clk cycles each row is driven (dwell); min 2.
- DEBOUNCE_SCANS, 4, consecutive identical samples needed to accept a press or a release; min 1.
- REPEAT_DELAY, 50, samples held before first auto-repeat (optional feature only).
- REPEAT_PERIOD, 10, samples between repeats (optional feature only).

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- col_in  input  COLS  column sense lines, active-high, asynchronous to clk.
- row_out  output  ROWS  one-hot row drive, active-high.
- key_code  output  4  last accepted key, 1..ROWS*COLS; 0 = none since reset.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while an accepted key remains pressed.

Behaviour:
- Reset (async, immediate, also mid-operation): row_out=1 (row 0), divider=0, debounce count=0, key_code=0, key_valid=0, key_held=0, state=SCAN.
- col_in passes through a 2-flop synchronizer. All samples use the synchronized value col_s.
- Divider counts 0..SCAN_DIV-1 and raises sample strobe on count SCAN_DIV-1, which gives the lines settle time. It free-runs in all states.
- Column priority: if several col_s bits are set, the lowest index wins. The code is row*COLS+col+1.
- SCAN:
  - On each strobe with col_s==0, rotate row_out left, wrapping ROWS-1 to 0.
  - On a strobe with col_s!=0, latch row/col, set count=1 and go to DEBOUNCE. row_out freezes.
- DEBOUNCE:
  - On each strobe, if the winning column equals the latched column, count++. Otherwise go to SCAN and rotate to the next row.
  - When count reaches DEBOUNCE_SCANS (checked in the same strobe cycle), register key_code, pulse key_valid the next cycle, set key_held=1 and go to HOLD.
  - If DEBOUNCE_SCANS=1, the detect strobe itself accepts.
- HOLD:
  - row_out stays frozen.
  - Each strobe with col_s==0 increments the release count; any nonzero sample clears it.
  - When release count reaches DEBOUNCE_SCANS, set key_held=0, row_out=row 0 and go to SCAN. No pulse on release.
  - A different column appearing in HOLD is ignored until release.
- Latency: from the detect strobe to the key_valid pulse is (DEBOUNCE_SCANS-1)*SCAN_DIV+1 cycles.
- key_code holds its value until the next acceptance. key_valid is never high two consecutive cycles.
- Counter widths are $clog2 of their maximum value. Debounce and release counts saturate and do not wrap.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: in HOLD, a repeat counter increments per strobe while col_s!=0.
  - At REPEAT_DELAY it re-pulses key_valid with the same key_code, then re-pulses every REPEAT_PERIOD strobes.
  - The counter clears on entry to HOLD and on any zero sample.
- Undefined: no repeat logic is synthesized, and exactly one pulse is issued per press.

Decomposition:
- Package keypad_pkg: state enum {SCAN, DEBOUNCE, HOLD}, KEY_NONE=4'd0, KEY_CODE_W=4.
- Sub-module keypad_scan_tick: parameterized divider producing the sample strobe.
- Synchronizer and FSM live in the top module.

Test Plan:
All scenarios use ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE_SCANS=3.
1. Reset, idle -> row_out cycles 0001,0010,0100,1000,0001, 4 clk each; key_valid never asserted; key_code=0.
2. Hold col_in=3'b100 while row_out=0010 -> detect strobe T, key_valid pulse at T+9, key_code=6, key_held=1, row_out frozen at 0010.
3. Bounce: col_in high for one sample, low on the next -> no key_valid; scan resumes at row 0100.
4. Release after scenario 2 -> key_held falls after 3 zero samples (12 clk); row_out=0001; no pulse.
5. col_in=3'b011 on row 0 -> key_code=1 (lowest column wins).
6. nrst low mid-DEBOUNCE -> outputs immediately return to reset values. With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2: a held key re-pulses at 5, 7, 9 strobes after acceptance.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, key code constants and width helper for the keypad row driver
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} kp_state_e;

   localparam int                    KEY_CODE_W = 4;
   localparam logic [KEY_CODE_W-1:0] KEY_NONE   = 4'd0;

   // Width of a counter/index over 0..n-1, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// rtl/keypad_scan_tick.sv - free-running row dwell divider producing the column sample strobe
module keypad_scan_tick
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic clk,
   input  logic nrst,
   output logic strobe
);
   localparam int W = idx_w(SCAN_DIV);

   logic [W-1:0] div_cnt;

   // Strobe sits at the end of the dwell so the driven row has settled.
   assign strobe = (div_cnt == W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         div_cnt <= '0;
      end else if (strobe) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_row_driver.sv
// rtl/keypad_row_driver.sv - row strobe, column sampling, debounce and key encode for a keypad matrix
// Optional auto-repeat of a held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_row_driver
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 3,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [COLS-1:0]       col_in,
   output logic [ROWS-1:0]       row_out,
   output logic [KEY_CODE_W-1:0] key_code,
   output logic                  key_valid,
   output logic                  key_held
);
   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   localparam int DW = idx_w(DEBOUNCE_SCANS + 1);

   if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       ROWS < 1 || COLS < 1 || ROWS * COLS > 15) begin : g_param_check
      $error("keypad_row_driver: parameter out of range");
   end

   logic [COLS-1:0]       col_m, col_s;
   logic                  strobe, col_any, accept, rpt_fire;
   logic [CW-1:0]         win_col, lat_col, lat_col_n;
   logic [RW-1:0]         row_idx, row_idx_n, row_nxt;
   logic [DW-1:0]         cnt, cnt_n, cnt_inc;
   kp_state_e             state, state_n;
   logic [KEY_CODE_W-1:0] key_code_n;
   logic                  key_valid_n, key_held_n;

   keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk    (clk),
      .nrst   (nrst),
      .strobe (strobe)
   );

   // Lowest set column wins when several lines are high.
   always_comb begin
      win_col = '0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (col_s[i]) win_col = CW'(i);
      end
   end

   assign col_any = |col_s;
   assign row_nxt = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
   assign cnt_inc = (cnt == DW'(DEBOUNCE_SCANS)) ? cnt : cnt + 1'b1;
   assign row_out = ROWS'(1) << row_idx;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         col_m     <= '0;
         col_s     <= '0;
         state     <= SCAN;
         row_idx   <= '0;
         lat_col   <= '0;
         cnt       <= '0;
         key_code  <= KEY_NONE;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         col_m     <= col_in;
         col_s     <= col_m;
         state     <= state_n;
         row_idx   <= row_idx_n;
         lat_col   <= lat_col_n;
         cnt       <= cnt_n;
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
      end
   end

   // cnt counts matching samples in DEBOUNCE and zero samples in HOLD.
   always_comb begin
      state_n    = state;
      row_idx_n  = row_idx;
      lat_col_n  = lat_col;
      cnt_n      = cnt;
      key_code_n = key_code;
      key_held_n = key_held;
      accept     = 1'b0;
      if (strobe) begin
         unique case (state)
            SCAN: begin
               if (!col_any) begin
                  row_idx_n = row_nxt;
               end else begin
                  lat_col_n = win_col;
                  cnt_n     = DW'(1);
                  state_n   = DEBOUNCE;
                  accept    = (DEBOUNCE_SCANS == 1);
               end
            end
            DEBOUNCE: begin
               if (col_any && win_col == lat_col) begin
                  cnt_n  = cnt_inc;
                  accept = (cnt_inc == DW'(DEBOUNCE_SCANS));
               end else begin
                  cnt_n     = '0;
                  row_idx_n = row_nxt;
                  state_n   = SCAN;
               end
            end
            HOLD: begin
               if (col_any) begin
                  cnt_n = '0;
               end else if (cnt_inc == DW'(DEBOUNCE_SCANS)) begin
                  cnt_n      = '0;
                  key_held_n = 1'b0;
                  row_idx_n  = '0;
                  state_n    = SCAN;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: state_n = SCAN;
         endcase
      end
      if (accept) begin
         key_code_n = KEY_CODE_W'(int'(row_idx) * COLS + int'(win_col) + 1);
         key_held_n = 1'b1;
         cnt_n      = '0;
         state_n    = HOLD;
      end
      key_valid_n = accept || rpt_fire;
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int PW      = idx_w(RPT_MAX + 1);

   logic [PW-1:0] rpt_cnt, rpt_cnt_n, rpt_target;
   logic          rpt_armed, rpt_armed_n;

   // First repeat waits REPEAT_DELAY strobes, later ones REPEAT_PERIOD.
   assign rpt_target = rpt_armed ? PW'(REPEAT_PERIOD) : PW'(REPEAT_DELAY);

   always_comb begin
      rpt_cnt_n   = rpt_cnt;
      rpt_armed_n = rpt_armed;
      rpt_fire    = 1'b0;
      if (accept) begin
         rpt_cnt_n   = '0;
         rpt_armed_n = 1'b0;
      end else if (strobe && state == HOLD) begin
         if (!col_any) begin
            rpt_cnt_n   = '0;
            rpt_armed_n = 1'b0;
         end else if (rpt_cnt + 1'b1 == rpt_target) begin
            rpt_fire    = 1'b1;
            rpt_cnt_n   = '0;
            rpt_armed_n = 1'b1;
         end else begin
            rpt_cnt_n = rpt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else begin
         rpt_cnt   <= rpt_cnt_n;
         rpt_armed <= rpt_armed_n;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

endmodule
